// File: rtl/hermes_pkg.sv
// Shared types for the Hermes switch control: port enum, header layout,
// FSM/tracker states and the XY routing function.
package hermes_pkg;

  localparam int NPORT = 5;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } e_port;

  localparam int HDR_X_MSB = 15;
  localparam int HDR_X_LSB = 8;
  localparam int HDR_Y_MSB = 7;
  localparam int HDR_Y_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ROUTE,
    S_ACK
  } fsm_state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_SIZE,
    P_PAY
  } trk_state_t;

  // X is resolved fully before Y, which keeps XY routing deadlock-free
  function automatic e_port xy_route(
    input logic [7:0] tx,
    input logic [7:0] ty,
    input logic [7:0] rx,
    input logic [7:0] ry
  );
    if (tx > rx) return EAST;
    if (tx < rx) return WEST;
    if (ty > ry) return NORTH;
    if (ty < ry) return SOUTH;
    return LOCAL;
  endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr,
// scanning EAST..LOCAL cyclically.
module hermes_rr_arbiter
  import hermes_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  e_port            ptr,
  output logic [NPORT-1:0] grant,
  output e_port            idx
);

  logic       found;
  logic [2:0] j;

  always_comb begin
    grant = '0;
    idx   = EAST;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= NPORT; i++) begin
      j = 3'((int'(ptr) + i) % NPORT);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = e_port'(j);
      end
    end
  end

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes router routing/arbitration control: RR header pick, XY route,
// output claim and per-input flit tracking. Optional SWITCH_CONTROL_STATS_EN.
module hermes_switch_control
  import hermes_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NPORT-1:0]                 req_i,
  input  logic [NPORT-1:0][FLIT_WIDTH-1:0] head_i,
  input  logic [NPORT-1:0]                 xfer_i,
  output logic [NPORT-1:0]                 ack_o,
  output logic [NPORT-1:0]                 in_busy_o,
  output logic [NPORT-1:0]                 out_busy_o,
  output logic [NPORT-1:0][2:0]            out_sel_o,
  output logic [NPORT-1:0][2:0]            in_sel_o,
  input  logic [2:0]                       stat_sel_i,
  output logic [31:0]                      stat_o
);

  fsm_state_t             state;
  e_port                  ptr;
  e_port                  cur;
  e_port                  dst;
  e_port                  gidx;
  logic [NPORT-1:0]       elig;
  logic [NPORT-1:0]       grant;
  logic [NPORT-1:0]       rel;
  logic                   claim;
  trk_state_t             trk [NPORT];
  logic [FLIT_WIDTH-1:0]  cnt [NPORT];

  assign elig = req_i & ~in_busy_o;

  hermes_rr_arbiter u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign dst = xy_route(
    head_i[cur][HDR_X_MSB:HDR_X_LSB],
    head_i[cur][HDR_Y_MSB:HDR_Y_LSB],
    8'(ROUTER_X),
    8'(ROUTER_Y)
  );

  assign claim = (state == S_ROUTE) && !out_busy_o[dst];

  // Last-flit detection; the release itself is applied on the next edge
  always_comb begin
    rel = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (in_busy_o[p] && xfer_i[p]) begin
        rel[p] = (trk[p] == P_SIZE && head_i[p] == '0) ||
                 (trk[p] == P_PAY && cnt[p] == FLIT_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= LOCAL;
      cur        <= EAST;
      ack_o      <= '0;
      in_busy_o  <= '0;
      out_busy_o <= '0;
      out_sel_o  <= '0;
      in_sel_o   <= '0;
    end else begin
      ack_o <= '0;
      for (int p = 0; p < NPORT; p++) begin
        if (rel[p]) begin
          in_busy_o[p]            <= 1'b0;
          out_busy_o[in_sel_o[p]] <= 1'b0;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (|elig) state <= S_ARB;
        end
        S_ARB: begin
          if (|grant) begin
            cur   <= gidx;
            ptr   <= gidx;
            state <= S_ROUTE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          state <= S_IDLE;
          if (claim) begin
            out_busy_o[dst] <= 1'b1;
            in_busy_o[cur]  <= 1'b1;
            out_sel_o[dst]  <= cur;
            in_sel_o[cur]   <= dst;
            ack_o[cur]      <= 1'b1;
            state           <= S_ACK;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) begin
        trk[p] <= P_HDR;
        cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (in_busy_o[p] && xfer_i[p]) begin
          unique case (trk[p])
            P_HDR: trk[p] <= P_SIZE;
            P_SIZE: begin
              cnt[p] <= head_i[p];
              trk[p] <= rel[p] ? P_HDR : P_PAY;
            end
            P_PAY: begin
              cnt[p] <= cnt[p] - FLIT_WIDTH'(1);
              if (rel[p]) trk[p] <= P_HDR;
            end
            default: trk[p] <= P_HDR;
          endcase
        end
      end
    end
  end

`ifdef SWITCH_CONTROL_STATS_EN
  logic [31:0] pkt_cnt [NPORT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) pkt_cnt[p] <= '0;
    end else if (claim) begin
      pkt_cnt[dst] <= pkt_cnt[dst] + 32'd1;
    end
  end

  always_comb begin
    stat_o = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (stat_sel_i == 3'(p)) stat_o = pkt_cnt[p];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel_i;
  assign stat_o          = '0;
`endif

endmodule

// File: tb/tb_hermes_switch_control.sv
// Bench for hermes_switch_control at router (1,1): directed scenarios
// plus randomized traffic against a packet-level reference model.
module tb_hermes_switch_control;
  import hermes_pkg::*;

  localparam int FW = 32;
  localparam int RX = 1;
  localparam int RY = 1;
  localparam int WAIT_BOUND = 1000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [4:0]        req_i;
  logic [4:0][FW-1:0] head_i;
  logic [4:0]        xfer_i;
  logic [4:0]        ack_o;
  logic [4:0]        in_busy_o;
  logic [4:0]        out_busy_o;
  logic [4:0][2:0]   out_sel_o;
  logic [4:0][2:0]   in_sel_o;
  logic [2:0]        stat_sel_i;
  logic [31:0]       stat_o;

  hermes_switch_control #(
    .FLIT_WIDTH (FW),
    .ROUTER_X   (RX),
    .ROUTER_Y   (RY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .head_i     (head_i),
    .xfer_i     (xfer_i),
    .ack_o      (ack_o),
    .in_busy_o  (in_busy_o),
    .out_busy_o (out_busy_o),
    .out_sel_o  (out_sel_o),
    .in_sel_o   (in_sel_o),
    .stat_sel_i (stat_sel_i),
    .stat_o     (stat_o)
  );

  always #5 clock = ~clock;

  bit          pend [5];
  bit          conn [5];
  bit          rel_nx [5];
  bit          obusy [5];
  logic [15:0] hdr [5];
  int          size [5];
  int          sent [5];
  int          dstm [5];
  int          waitc [5];
  int unsigned stat_m [5];
  int          ack_q [$];
  int          xfer_pct;
  int          new_pct;
  bit          spur_en;
  int          n_chk;
  int          n_pass;

  function automatic int route(input logic [15:0] h);
    int tx;
    int ty;
    tx = int'(h[15:8]);
    ty = int'(h[7:0]);
    if (tx > RX) return 0;
    if (tx < RX) return 1;
    if (ty > RY) return 2;
    if (ty < RY) return 3;
    return 4;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = 1'b0;
    for (int p = 0; p < 5; p++) b |= pend[p] | conn[p] | rel_nx[p];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int p = 0; p < 5; p++) begin
      pend[p] = 0; conn[p] = 0; rel_nx[p] = 0; obusy[p] = 0;
      hdr[p] = '0; size[p] = 0; sent[p] = 0; dstm[p] = 0;
      waitc[p] = 0; stat_m[p] = 0;
    end
    ack_q.delete();
  endtask

  task automatic monitor();
    logic [4:0] eib;
    logic [4:0] eob;
    int d;
    check("ack_onehot", 32'($onehot0(ack_o)), 1);
    for (int p = 0; p < 5; p++) begin
      if (ack_o[p]) begin
        d = route(hdr[p]);
        check($sformatf("ack_legal_p%0d", p),
              32'(pend[p] && !conn[p] && !obusy[d]), 1);
      end
    end
    for (int p = 0; p < 5; p++) begin
      if (rel_nx[p]) begin
        rel_nx[p] = 0;
        conn[p] = 0;
        obusy[dstm[p]] = 0;
      end
    end
    for (int p = 0; p < 5; p++) begin
      if (ack_o[p] && pend[p] && !conn[p]) begin
        d = route(hdr[p]);
        pend[p] = 0; conn[p] = 1; dstm[p] = d; sent[p] = 0;
        obusy[d] = 1; stat_m[d]++; waitc[p] = 0;
        ack_q.push_back(p);
      end
    end
    eib = '0;
    eob = '0;
    for (int p = 0; p < 5; p++) begin
      eib[p] = conn[p];
      eob[p] = obusy[p];
    end
    check("in_busy", in_busy_o, eib);
    check("out_busy", out_busy_o, eob);
    for (int p = 0; p < 5; p++) begin
      if (conn[p]) begin
        check($sformatf("in_sel_p%0d", p), in_sel_o[p], dstm[p]);
        check($sformatf("out_sel_q%0d", dstm[p]), out_sel_o[dstm[p]], p);
      end
      if (pend[p]) begin
        waitc[p]++;
        check($sformatf("ack_wait_p%0d", p), 32'(waitc[p] < WAIT_BOUND), 1);
      end
    end
  endtask

  task automatic drive();
    int s;
    logic [7:0] tx;
    logic [7:0] ty;
    for (int p = 0; p < 5; p++) begin
      if (!pend[p] && !conn[p] && $urandom_range(99) < new_pct) begin
        tx = ($urandom_range(3) == 3) ? 8'($urandom) : 8'($urandom_range(2));
        ty = ($urandom_range(3) == 3) ? 8'($urandom) : 8'($urandom_range(2));
        s = ($urandom_range(7) == 0) ? $urandom_range(16) : $urandom_range(3);
        pend[p] = 1; hdr[p] = {tx, ty}; size[p] = s; waitc[p] = 0;
      end
      req_i[p] = pend[p] && !conn[p];
      if (conn[p]) begin
        if (sent[p] == 0) head_i[p] = FW'(hdr[p]);
        else if (sent[p] == 1) head_i[p] = FW'(size[p]);
        else head_i[p] = $urandom;
        xfer_i[p] = ($urandom_range(99) < xfer_pct);
        if (xfer_i[p]) begin
          sent[p]++;
          if (sent[p] == size[p] + 2) rel_nx[p] = 1;
        end
      end else begin
        head_i[p] = pend[p] ? FW'(hdr[p]) : FW'($urandom);
        xfer_i[p] = spur_en && ($urandom_range(9) == 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    monitor();
    drive();
  endtask

  task automatic add_pkt(input int p, input logic [15:0] h, input int s);
    pend[p] = 1; hdr[p] = h; size[p] = s; waitc[p] = 0;
    req_i[p] = 1'b1;
    head_i[p] = FW'(h);
    xfer_i[p] = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int k;
    k = 0;
    while (model_busy() && k < maxc) begin
      tick();
      k++;
    end
    check({tag, "_drain"}, 32'(model_busy()), 0);
    repeat (3) tick();
  endtask

  task automatic stats_check(input string tag);
    logic [31:0] e;
    for (int s = 0; s < 8; s++) begin
      stat_sel_i = 3'(s);
      #1;
`ifdef SWITCH_CONTROL_STATS_EN
      e = (s < 5) ? stat_m[s] : 32'd0;
`else
      e = 32'd0;
`endif
      check($sformatf("%s_stat%0d", tag, s), stat_o, e);
    end
    stat_sel_i = '0;
  endtask

  initial begin
    req_i = '0; xfer_i = '0; head_i = '0; stat_sel_i = '0;
    xfer_pct = 100; new_pct = 0; spur_en = 0;
    n_chk = 0; n_pass = 0;
    model_clear();

    repeat (3) @(posedge clock);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_in_busy", in_busy_o, 0);
    check("rst_out_busy", out_busy_o, 0);
    check("rst_out_sel", 32'(out_sel_o), 0);
    check("rst_in_sel", 32'(in_sel_o), 0);
    check("rst_stat", stat_o, 0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    reset = 1'b1;

    // LOCAL -> EAST, size 3: ack on third edge, release one cycle after 5th flit
    add_pkt(4, 16'h0201, 3);
    tick(); check("t1_ack_c1", ack_o, 0);
    tick(); check("t1_ack_c2", ack_o, 0);
    tick(); check("t1_ack_c3", ack_o, 5'b10000);
    check("t1_obusy_e", out_busy_o[0], 1);
    check("t1_osel_e", out_sel_o[0], 4);
    check("t1_isel_l", in_sel_o[4], 0);
    repeat (4) tick();
    check("t1_hold", out_busy_o[0], 1);
    tick();
    check("t1_release", out_busy_o[0], 0);
    drain("t1", 50);

    // WEST and NORTH contend for LOCAL, size 0 each
    ack_q.delete();
    add_pkt(1, 16'h0101, 0);
    add_pkt(2, 16'h0101, 0);
    drain("t2a", 100);
    check("t2a_nacks", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("t2a_first", ack_q[0], 1);
      check("t2a_second", ack_q[1], 2);
    end

    add_pkt(1, 16'h0101, 1);
    drain("t2b", 100);

    // WEST was served last, so NORTH now goes first
    ack_q.delete();
    add_pkt(1, 16'h0101, 0);
    add_pkt(2, 16'h0101, 0);
    drain("t2c", 100);
    check("t2c_nacks", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("t2c_first", ack_q[0], 2);
      check("t2c_second", ack_q[1], 1);
    end

    // four concurrent connections to distinct outputs
    xfer_pct = 0;
    add_pkt(0, 16'h0001, 10);
    add_pkt(1, 16'h0201, 10);
    add_pkt(2, 16'h0100, 10);
    add_pkt(3, 16'h0102, 10);
    for (int k = 0; k < 80 && !(conn[0] && conn[1] && conn[2] && conn[3]); k++)
      tick();
    check("t4_in_busy", in_busy_o, 5'b01111);
    check("t4_out_busy", out_busy_o, 5'b01111);
    check("t4_isel_e", in_sel_o[0], 1);
    check("t4_isel_w", in_sel_o[1], 0);
    check("t4_isel_n", in_sel_o[2], 3);
    check("t4_isel_s", in_sel_o[3], 2);
    check("t4_osel_w", out_sel_o[1], 0);
    check("t4_osel_e", out_sel_o[0], 1);
    check("t4_osel_s", out_sel_o[3], 2);
    check("t4_osel_n", out_sel_o[2], 3);

    // reset lands mid-payload, between clock edges
    xfer_pct = 100;
    repeat (4) tick();
    #3;
    reset = 1'b0;
    #1;
    check("t5_in_busy", in_busy_o, 0);
    check("t5_out_busy", out_busy_o, 0);
    check("t5_ack", ack_o, 0);
    check("t5_state", 32'(dut.state), 32'(S_IDLE));
    model_clear();
    req_i = '0; xfer_i = '0; head_i = '0;
    @(posedge clock);
    #1;
    check("t5_held", in_busy_o, 0);
    reset = 1'b1;

    // three packets to EAST, one to WEST
    add_pkt(4, 16'h0201, 0);
    drain("t6a", 100);
    add_pkt(4, 16'h0205, 1);
    drain("t6b", 100);
    add_pkt(3, 16'hFF00, 2);
    drain("t6c", 100);
    add_pkt(0, 16'h0001, 0);
    drain("t6d", 100);
    stats_check("t6");

    // randomized traffic
    xfer_pct = 70;
    new_pct = 15;
    spur_en = 1;
    repeat (3000) tick();
    new_pct = 0;
    drain("rnd", 3000);
    stats_check("rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
